// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// traffic_light_ctrl
// ----------------------------------------------------------------------------
// Two-approach actuated traffic-light controller. A prescaler divides the
// board clock down to a one-clock timing tick. All phase timing advances on
// that tick. Greens gap out when the own-approach sensor drops after the
// minimum green. They max out after T_GREEN_MAX when cross demand persists.
// With no opposing demand the current green rests indefinitely.
// Pedestrian buttons are latched on any clock. A latched request both
// creates demand and arms the walk signal of the next matching green.
//
// Ports
//   CLK     in   board clock (the only clock)
//   RST     in   asynchronous, active-high reset
//   SA, SB  in   vehicle present on approach A / B (sampled on tick only)
//   PBTN_A  in   pedestrian request parallel to A (latched, any width)
//   PBTN_B  in   pedestrian request parallel to B
//   A, B    out  lights: 2'b00 red, 2'b01 yellow, 2'b10 green
//   PA, PB  out  walk signals parallel to A / B
//   PHASE   out  current state code (debug)
//   TICK    out  one-clock timing tick (debug)
// All outputs come straight from flops.
// ============================================================================
module traffic_light_ctrl #(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned T_GREEN_MIN = 5,
   parameter int unsigned T_GREEN_MAX = 30,
   parameter int unsigned T_YELLOW    = 3,
   parameter int unsigned T_ALLRED    = 1,
   parameter int unsigned T_WALK      = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SA,
   input  logic       SB,
   input  logic       PBTN_A,
   input  logic       PBTN_B,
   output logic [1:0] A,
   output logic [1:0] B,
   output logic       PA,
   output logic       PB,
   output logic [2:0] PHASE,
   output logic       TICK
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int unsigned PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // Elapsed count is one bit wider so tcnt+1 never wraps at saturation.
   localparam int unsigned EL_W   = CNT_W + 1;

   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
   localparam logic [PCNT_W-1:0] PCNT_ZERO = {PCNT_W{1'b0}};
   localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

   localparam logic [EL_W-1:0]   EL_ONE    = EL_W'(1);
   localparam logic [EL_W-1:0]   EL_GMIN   = EL_W'(T_GREEN_MIN);
   localparam logic [EL_W-1:0]   EL_GMAX   = EL_W'(T_GREEN_MAX);
   localparam logic [EL_W-1:0]   EL_YEL    = EL_W'(T_YELLOW);
   localparam logic [EL_W-1:0]   EL_ARED   = EL_W'(T_ALLRED);

   localparam logic [CNT_W-1:0]  TC_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  TC_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  TC_SAT    = CNT_W'(T_GREEN_MAX);
   localparam logic [CNT_W-1:0]  TC_WALK   = CNT_W'(T_WALK);

   // State codes are visible on PHASE and must stay stable.
   localparam logic [2:0] ST_ALLRED_BA = 3'd0;
   localparam logic [2:0] ST_A_GREEN   = 3'd1;
   localparam logic [2:0] ST_A_YELLOW  = 3'd2;
   localparam logic [2:0] ST_ALLRED_AB = 3'd3;
   localparam logic [2:0] ST_B_GREEN   = 3'd4;
   localparam logic [2:0] ST_B_YELLOW  = 3'd5;

   localparam logic [1:0] LAMP_RED     = 2'b00;
   localparam logic [1:0] LAMP_YELLOW  = 2'b01;
   localparam logic [1:0] LAMP_GREEN   = 2'b10;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   // Lamp for one approach given the state and that approach's own codes.
   // Anything that is not the approach's own green/yellow shows red, which
   // keeps the opposing approach red by construction.
   function automatic logic [1:0] lamp_decode(input logic [2:0] st,
                                              input logic [2:0] st_green,
                                              input logic [2:0] st_yellow);
      logic [1:0] lamp;
      if (st == st_green) begin
         lamp = LAMP_GREEN;
      end else if (st == st_yellow) begin
         lamp = LAMP_YELLOW;
      end else begin
         lamp = LAMP_RED;
      end
      return lamp;
   endfunction

   // Green may end once the minimum has run, someone is waiting across, and
   // either the own approach is empty (gap-out) or the maximum is reached.
   function automatic logic green_done(input logic [EL_W-1:0] elapsed,
                                       input logic            opp_demand,
                                       input logic            own_sensor);
      return (elapsed >= EL_GMIN) && opp_demand &&
             (!own_sensor || (elapsed >= EL_GMAX));
   endfunction

   // ------------------------------------------------------------------------
   // Registers and next-state signals
   // ------------------------------------------------------------------------
   logic [PCNT_W-1:0] pcnt_r,   pcnt_nx_s;
   logic              tick_r,   tick_nx_s;
   logic [2:0]        state_r,  state_nx_s;
   logic [CNT_W-1:0]  tcnt_r,   tcnt_nx_s;
   logic              req_a_r,  req_a_nx_s;
   logic              req_b_r,  req_b_nx_s;
   logic              walk_a_r, walk_a_nx_s;
   logic              walk_b_r, walk_b_nx_s;
   logic [1:0]        a_r,      a_nx_s;
   logic [1:0]        b_r,      b_nx_s;
   logic              pa_r,     pa_nx_s;
   logic              pb_r,     pb_nx_s;

   logic [EL_W-1:0]   elapsed_s;
   logic              demand_a_s;
   logic              demand_b_s;
   logic              enter_a_s;
   logic              enter_b_s;
   logic              state_chg_s;

   // ------------------------------------------------------------------------
   // Prescaler
   // ------------------------------------------------------------------------
   // Next prescaler count and the registered tick that marks its last value.
   always_comb begin
      pcnt_nx_s = pcnt_r;
      if (pcnt_r == PCNT_LAST) begin
         pcnt_nx_s = PCNT_ZERO;
      end else begin
         pcnt_nx_s = pcnt_r + PCNT_ONE;
      end
      // Registering the compare on the next count keeps TICK aligned with
      // the cycle in which pcnt holds its last value.
      tick_nx_s = (pcnt_nx_s == PCNT_LAST);
   end

   // Prescaler and tick flops.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt_r <= PCNT_ZERO;
         tick_r <= 1'b0;
      end else begin
         pcnt_r <= pcnt_nx_s;
         tick_r <= tick_nx_s;
      end
   end

   // ------------------------------------------------------------------------
   // Phase sequencing
   // ------------------------------------------------------------------------
   // Elapsed ticks including the current one, plus latched demand.
   always_comb begin
      elapsed_s  = {1'b0, tcnt_r} + EL_ONE;
      demand_a_s = SA | req_a_r;
      demand_b_s = SB | req_b_r;
   end

   // Next phase; only a tick may move the state.
   always_comb begin
      state_nx_s = state_r;
      if (tick_r) begin
         case (state_r)
            ST_ALLRED_BA: begin
               if (elapsed_s >= EL_ARED) begin
                  state_nx_s = ST_A_GREEN;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_A_GREEN: begin
               if (green_done(elapsed_s, demand_b_s, SA)) begin
                  state_nx_s = ST_A_YELLOW;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_A_YELLOW: begin
               if (elapsed_s >= EL_YEL) begin
                  state_nx_s = ST_ALLRED_AB;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_ALLRED_AB: begin
               if (elapsed_s >= EL_ARED) begin
                  state_nx_s = ST_B_GREEN;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_B_GREEN: begin
               if (green_done(elapsed_s, demand_a_s, SB)) begin
                  state_nx_s = ST_B_YELLOW;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_B_YELLOW: begin
               if (elapsed_s >= EL_YEL) begin
                  state_nx_s = ST_ALLRED_BA;
               end else begin
                  state_nx_s = state_r;
               end
            end
            default: begin
               // Unused codes fall back to a safe all-red state.
               state_nx_s = ST_ALLRED_BA;
            end
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Phase timer: clears on any state change, counts ticks, saturates.
   always_comb begin
      state_chg_s = (state_nx_s != state_r);
      tcnt_nx_s   = tcnt_r;
      if (state_chg_s) begin
         tcnt_nx_s = TC_ZERO;
      end else if (tick_r && (tcnt_r < TC_SAT)) begin
         tcnt_nx_s = tcnt_r + TC_ONE;
      end else begin
         tcnt_nx_s = tcnt_r;
      end
   end

   // State and phase timer flops.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_ALLRED_BA;
         tcnt_r  <= TC_ZERO;
      end else begin
         state_r <= state_nx_s;
         tcnt_r  <= tcnt_nx_s;
      end
   end

   // ------------------------------------------------------------------------
   // Pedestrian requests and walk arming
   // ------------------------------------------------------------------------
   // On entry to a green the request is consumed (a press in that same clock
   // is consumed too) and the walk flag is armed from request-or-press.
   always_comb begin
      enter_a_s = (state_nx_s == ST_A_GREEN) && (state_r != ST_A_GREEN);
      enter_b_s = (state_nx_s == ST_B_GREEN) && (state_r != ST_B_GREEN);

      req_a_nx_s  = req_a_r;
      walk_a_nx_s = walk_a_r;
      if (enter_a_s) begin
         req_a_nx_s  = 1'b0;
         walk_a_nx_s = req_a_r | PBTN_A;
      end else if (PBTN_A) begin
         req_a_nx_s  = 1'b1;
         walk_a_nx_s = walk_a_r;
      end else begin
         req_a_nx_s  = req_a_r;
         walk_a_nx_s = walk_a_r;
      end

      req_b_nx_s  = req_b_r;
      walk_b_nx_s = walk_b_r;
      if (enter_b_s) begin
         req_b_nx_s  = 1'b0;
         walk_b_nx_s = req_b_r | PBTN_B;
      end else if (PBTN_B) begin
         req_b_nx_s  = 1'b1;
         walk_b_nx_s = walk_b_r;
      end else begin
         req_b_nx_s  = req_b_r;
         walk_b_nx_s = walk_b_r;
      end
   end

   // Request and walk-arm flops.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         req_a_r  <= 1'b0;
         req_b_r  <= 1'b0;
         walk_a_r <= 1'b0;
         walk_b_r <= 1'b0;
      end else begin
         req_a_r  <= req_a_nx_s;
         req_b_r  <= req_b_nx_s;
         walk_a_r <= walk_a_nx_s;
         walk_b_r <= walk_b_nx_s;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------------
   // Outputs are decoded from the next register values and then registered,
   // so they change on exactly the same edge as the state they describe.
   always_comb begin
      a_nx_s  = lamp_decode(state_nx_s, ST_A_GREEN, ST_A_YELLOW);
      b_nx_s  = lamp_decode(state_nx_s, ST_B_GREEN, ST_B_YELLOW);
      pa_nx_s = (state_nx_s == ST_A_GREEN) && walk_a_nx_s &&
                (tcnt_nx_s < TC_WALK);
      pb_nx_s = (state_nx_s == ST_B_GREEN) && walk_b_nx_s &&
                (tcnt_nx_s < TC_WALK);
   end

   // Output flops.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_r  <= LAMP_RED;
         b_r  <= LAMP_RED;
         pa_r <= 1'b0;
         pb_r <= 1'b0;
      end else begin
         a_r  <= a_nx_s;
         b_r  <= b_nx_s;
         pa_r <= pa_nx_s;
         pb_r <= pb_nx_s;
      end
   end

   assign A     = a_r;
   assign B     = b_r;
   assign PA    = pa_r;
   assign PB    = pb_r;
   assign PHASE = state_r;
   assign TICK  = tick_r;

endmodule
